// File: rtl/program_loader.sv
// program_loader: streams a program into instruction memory from address 0,
// validates it against a trailing 32-bit additive checksum, and releases the
// processor only after a load completes with a matching checksum.
//
// Ports:
//   clk, clr                 clock, synchronous active-high reset
//   load_start, load_len     start pulse and program length (excl. checksum)
//   in_valid, in_data        word stream: program words then checksum
//   in_ready                 loader accepts a word this cycle (state decode)
//   mem_wen/mem_addr/mem_data registered instruction-memory write port
//   cpu_hold, run            processor held in clear / released
//   busy                     load or checksum phase in progress
//   err, err_code            sticky error flag and cause
//   word_count               program words accepted in the current load
module program_loader #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 256
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              load_start,
    input  logic [ADDR_W:0]   load_len,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              cpu_hold,
    output logic              run,
    output logic              busy,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [ADDR_W:0]   word_count
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [ADDR_W:0] DEPTH_L = CNT_W'(DEPTH);

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_CHECKSUM = 2'b01;
    localparam logic [1:0] ERR_ZERO_LEN = 2'b10;
    localparam logic [1:0] ERR_TOO_LONG = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CHECK,
        S_RUN,
        S_ERROR
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        err_code_q, err_code_d;
    logic              start_c;      // begin a new load: latch length, clear counters
    logic              accept_c;     // program word accepted this cycle
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   wc_q;
    logic [ADDR_W:0]   wc_inc;
    logic [DATA_W-1:0] acc_q;
    logic              mem_wen_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_data_q;
    logic              cpu_hold_q, run_q, busy_q, err_q;

    assign wc_inc = wc_q + CNT_W'(1);

    // State register
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, error code and datapath strobes
    always_comb begin
        state_d    = state_q;
        err_code_d = err_code_q;
        start_c    = 1'b0;
        accept_c   = 1'b0;
        case (state_q)
            S_IDLE, S_RUN, S_ERROR: begin
                if (load_start) begin
                    // A new request always clears a previous error first.
                    err_code_d = ERR_NONE;
                    if (load_len == '0) begin
                        state_d    = S_ERROR;
                        err_code_d = ERR_ZERO_LEN;
                    end else if (load_len > DEPTH_L) begin
                        state_d    = S_ERROR;
                        err_code_d = ERR_TOO_LONG;
                    end else begin
                        state_d = S_LOAD;
                        start_c = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                if (in_valid) begin
                    accept_c = 1'b1;
                    if (wc_inc == len_q) begin
                        state_d = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                if (in_valid) begin
                    if (in_data == acc_q) begin
                        state_d = S_RUN;
                    end else begin
                        state_d    = S_ERROR;
                        err_code_d = ERR_CHECKSUM;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Datapath and registered status outputs, decoded from the next state so
    // they change on the same edge as the state.
    always_ff @(posedge clk) begin
        if (clr) begin
            mem_wen_q  <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            wc_q       <= '0;
            acc_q      <= '0;
            len_q      <= '0;
            err_code_q <= ERR_NONE;
            cpu_hold_q <= 1'b1;
            run_q      <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            mem_wen_q <= accept_c;
            if (accept_c) begin
                mem_addr_q <= wc_q[ADDR_W-1:0];
                mem_data_q <= in_data;
                wc_q       <= wc_inc;
                acc_q      <= acc_q + in_data;
            end
            if (start_c) begin
                wc_q  <= '0;
                acc_q <= '0;
                len_q <= load_len;
            end
            err_code_q <= err_code_d;
            cpu_hold_q <= (state_d != S_RUN);
            run_q      <= (state_d == S_RUN);
            busy_q     <= (state_d == S_LOAD) || (state_d == S_CHECK);
            err_q      <= (state_d == S_ERROR);
        end
    end

    // Ready depends on state only, never on in_valid.
    assign in_ready   = (state_q == S_LOAD) || (state_q == S_CHECK);
    assign mem_wen    = mem_wen_q;
    assign mem_addr   = mem_addr_q;
    assign mem_data   = mem_data_q;
    assign cpu_hold   = cpu_hold_q;
    assign run        = run_q;
    assign busy       = busy_q;
    assign err        = err_q;
    assign err_code   = err_code_q;
    assign word_count = wc_q;

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed self-checking bench for program_loader.
module tb_program_loader;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 256;

    logic              clk;
    logic              clr;
    logic              load_start;
    logic [ADDR_W:0]   load_len;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              mem_wen;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              cpu_hold;
    logic              run;
    logic              busy;
    logic              err;
    logic [1:0]        err_code;
    logic [ADDR_W:0]   word_count;

    int n_checks;
    int n_errors;

    program_loader #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .clr       (clr),
        .load_start(load_start),
        .load_len  (load_len),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_wen   (mem_wen),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .cpu_hold  (cpu_hold),
        .run       (run),
        .busy      (busy),
        .err       (err),
        .err_code  (err_code),
        .word_count(word_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Status outputs as one packed word: {cpu_hold, run, busy, err, in_ready}
    function automatic logic [31:0] status();
        return 32'({cpu_hold, run, busy, err, in_ready});
    endfunction

    task automatic start(input logic [ADDR_W:0] len);
        load_start = 1'b1;
        load_len   = len;
        tick();
        load_start = 1'b0;
    endtask

    task automatic push(input logic [31:0] w, input logic [31:0] exp_addr, input string tag);
        in_valid = 1'b1;
        in_data  = w;
        tick();
        in_valid = 1'b0;
        chk({tag, "_wen"},  32'(mem_wen),  32'd1);
        chk({tag, "_addr"}, 32'(mem_addr), exp_addr);
        chk({tag, "_data"}, mem_data,      w);
    endtask

    int idx;
    int budget;
    int last_addr;
    logic v;

    initial begin
        clk        = 1'b0;
        clr        = 1'b1;
        load_start = 1'b0;
        load_len   = '0;
        in_valid   = 1'b0;
        in_data    = '0;
        n_checks   = 0;
        n_errors   = 0;

        // Reset state
        tick();
        chk("rst_status", status(), 32'b10000);
        chk("rst_wen",    32'(mem_wen),    32'd0);
        chk("rst_code",   32'(err_code),   32'd0);
        chk("rst_wc",     32'(word_count), 32'd0);
        chk("rst_addr",   32'(mem_addr),   32'd0);
        chk("rst_data",   mem_data,        32'd0);
        clr = 1'b0;

        // 1: three words, back-to-back, good checksum.
        // 0x20080005 + 0x20090007 + 0x01095020 = 0x411A502C (mod 2^32).
        start(9'd3);
        chk("t1_status_load", status(), 32'b10101);
        chk("t1_wc0", 32'(word_count), 32'd0);
        in_valid = 1'b1;
        in_data = 32'h20080005; tick();
        chk("t1_w0_wen", 32'(mem_wen), 32'd1); chk("t1_w0_addr", 32'(mem_addr), 32'd0);
        chk("t1_w0_data", mem_data, 32'h20080005);
        in_data = 32'h20090007; tick();
        chk("t1_w1_wen", 32'(mem_wen), 32'd1); chk("t1_w1_addr", 32'(mem_addr), 32'd1);
        in_data = 32'h01095020; tick();
        chk("t1_w2_wen", 32'(mem_wen), 32'd1); chk("t1_w2_addr", 32'(mem_addr), 32'd2);
        chk("t1_w2_data", mem_data, 32'h01095020);
        chk("t1_wc3", 32'(word_count), 32'd3);
        chk("t1_check_ready", 32'(in_ready), 32'd1);
        in_data = 32'h411A502C; tick();
        in_valid = 1'b0;
        chk("t1_ck_nowen", 32'(mem_wen), 32'd0);
        chk("t1_run_status", status(), 32'b01000);
        chk("t1_wc_final", 32'(word_count), 32'd3);

        // in_valid outside LOAD/CHECK consumes nothing
        in_valid = 1'b1; in_data = 32'hFFFF0000; tick(); in_valid = 1'b0;
        chk("run_ignore_wen", 32'(mem_wen), 32'd0);
        chk("run_ignore_wc", 32'(word_count), 32'd3);

        // 6: restart from RUN; load_start during LOAD is ignored
        start(9'd1);
        chk("t6_restart_status", status(), 32'b10101);
        chk("t6_restart_wc", 32'(word_count), 32'd0);
        load_start = 1'b1; load_len = 9'd5; tick(); load_start = 1'b0;
        chk("t6_ignore_status", status(), 32'b10101);
        chk("t6_ignore_wc", 32'(word_count), 32'd0);
        chk("t6_stall_wen", 32'(mem_wen), 32'd0);
        push(32'hDEADBEEF, 32'd0, "t6_w0");
        chk("t6_in_check", status(), 32'b10101);
        in_valid = 1'b1; in_data = 32'hDEADBEEF; tick(); in_valid = 1'b0;
        chk("t6_run", status(), 32'b01000);

        // 2: bad checksum
        start(9'd3);
        push(32'h20080005, 32'd0, "t2_w0");
        push(32'h20090007, 32'd1, "t2_w1");
        chk("t2_norun_mid", 32'(run), 32'd0);
        push(32'h01095020, 32'd2, "t2_w2");
        in_valid = 1'b1; in_data = 32'h00000000; tick(); in_valid = 1'b0;
        chk("t2_err_status", status(), 32'b10010);
        chk("t2_err_code", 32'(err_code), 32'd1);
        tick();
        chk("t2_err_sticky", status(), 32'b10010);

        // 3: length errors, then a valid start clears the error
        start(9'd0);
        chk("t3_zero_code", 32'(err_code), 32'd2);
        chk("t3_zero_err", status(), 32'b10010);
        start(9'd257);
        chk("t3_long_code", 32'(err_code), 32'd3);
        start(9'd2);
        chk("t3_clear_code", 32'(err_code), 32'd0);
        chk("t3_clear_status", status(), 32'b10101);
        push(32'd1, 32'd0, "t3_w0");
        push(32'd2, 32'd1, "t3_w1");
        in_valid = 1'b1; in_data = 32'd3; tick(); in_valid = 1'b0;
        chk("t3_run", status(), 32'b01000);

        // 4: full-depth load with random valid gaps; sum(0..255) = 0x7F80
        start(9'd256);
        idx = 0;
        budget = 0;
        last_addr = -1;
        while (idx < 256 && budget < 3000) begin
            v = 1'($urandom_range(0, 1));
            in_valid = v;
            in_data  = 32'(idx);
            tick();
            chk("t4_wen", 32'(mem_wen), 32'(v));
            if (v) begin
                chk("t4_addr", 32'(mem_addr), 32'(idx));
                chk("t4_data", mem_data, 32'(idx));
                last_addr = int'(mem_addr);
                idx++;
            end
            budget++;
        end
        in_valid = 1'b0;
        chk("t4_budget", 32'(idx), 32'd256);
        chk("t4_last_addr", 32'(last_addr), 32'hFF);
        chk("t4_wc", 32'(word_count), 32'd256);
        chk("t4_in_check", status(), 32'b10101);
        in_valid = 1'b1; in_data = 32'h00007F80; tick(); in_valid = 1'b0;
        chk("t4_run", status(), 32'b01000);
        chk("t4_ck_nowen", 32'(mem_wen), 32'd0);

        // 5: clr mid-load, then a 1-word load from address 0
        start(9'd5);
        push(32'hA, 32'd0, "t5_w0");
        push(32'hB, 32'd1, "t5_w1");
        in_valid = 1'b1; in_data = 32'hC; clr = 1'b1; tick();
        clr = 1'b0; in_valid = 1'b0;
        chk("t5_clr_status", status(), 32'b10000);
        chk("t5_clr_wc", 32'(word_count), 32'd0);
        chk("t5_clr_wen", 32'(mem_wen), 32'd0);
        start(9'd1);
        push(32'h12345678, 32'd0, "t5_new_w0");
        in_valid = 1'b1; in_data = 32'h12345678; tick(); in_valid = 1'b0;
        chk("t5_run", status(), 32'b01000);
        chk("t5_code", 32'(err_code), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
